div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and the result width at 64 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high (`RstEnable` = 1'b1).
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 opdata1_i  input  32  dividend; sampled with start_i.
REQ-006 opdata2_i  input  32  divisor; sampled with start_i.
REQ-007 start_i  input  1  `DivStart` = 1 requests an operation; the requester SHALL hold it high until ready_o is seen.
REQ-008 annul_i  input  1  1 = abandon the current operation (pipeline flush).
REQ-009 result_o  output  64  {remainder[31:0] -> HI, quotient[31:0] -> LO}.
REQ-010 ready_o  output  1  `DivResultReady` = 1 while result_o is valid.

Function
REQ-011 The block SHALL implement four states: DivFree, DivByZero, DivOn, DivEnd.
REQ-012 DivFree behaviour:
- start_i=1 and annul_i=0 at edge E0: latch operands and sign mode.
- Next state SHALL be DivByZero if opdata2_i==0, else DivOn with the iteration counter cnt=0.
- start_i=0: remain in DivFree.
REQ-013 Signed mode SHALL divide absolute values (two's-complement negation of negative operands); unsigned mode SHALL use the operands as-is.
REQ-014 DivOn SHALL perform one restoring shift-subtract iteration per cycle.
- 32 iterations on edges E1..E32, cnt incrementing 0..32.
- The partial remainder SHALL be 33 bits wide so that no carry is lost.
REQ-015 Result edge:
- On edge E33 (cnt==32), the sign fix-up SHALL be applied and the state SHALL move to DivEnd.
- In the same edge, result_o SHALL be registered and ready_o SHALL be set to 1.
- Latency start-to-ready SHALL therefore be 33 cycles.
REQ-016 Sign fix-up: the quotient SHALL be negated iff signed_div=1 and the latched operand signs differ; the remainder SHALL be negated iff signed_div=1 and the dividend was negative.
REQ-017 Overflow (0x80000000 / 0xFFFFFFFF signed) SHALL wrap to quotient 0x80000000, remainder 0, with no error signal.
REQ-018 DivByZero SHALL move to DivEnd on E1 with result_o=64'h0 and ready_o=1.
REQ-019 DivEnd SHALL hold result_o and ready_o stable while start_i=1.
REQ-020 In DivEnd, on the first edge with start_i=0, the state SHALL return to DivFree, with ready_o=0 and result_o=0.
REQ-021 annul_i=1 in DivOn or DivByZero SHALL return the state to DivFree on the next edge.
- ready_o SHALL NOT assert for the annulled operation.
- A new start SHALL be accepted on the edge after the return to DivFree.
REQ-022 start_i changes and operand changes while in DivOn or DivEnd SHALL be ignored (operands are latched).
REQ-023 Outside DivEnd, ready_o SHALL be 0 and result_o SHALL be 64'h0.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force:
- state=DivFree, cnt=0;
- ready_o=0, result_o=64'h0;
- all latched operands and partial results to 0.
REQ-025 Reset asserted mid-operation SHALL discard the operation; after release the block SHALL accept a new start on the first edge.

Verification
REQ-026 Unsigned 100/7, start at E0 -> ready_o=1 exactly at E33, result_o=64'h00000002_0000000E; ready_o=0 at every earlier edge.
REQ-027 Signed 0xFFFFFFF9/2 (-7/2) -> result_o=64'hFFFFFFFF_FFFFFFFD; signed 7/0xFFFFFFFE -> 64'h00000001_FFFFFFFD.
REQ-028 Divide by zero (any dividend, divisor 0) -> ready_o=1 at E1, result_o=0.
- Hold start_i for 3 more cycles -> ready_o and result_o stay stable.
- Drop start_i -> ready_o=0 on the next edge.
REQ-029 Annul at cnt==10 -> DivFree on the next edge, ready_o never asserts.
- A following unsigned 0xFFFFFFFF/1 -> result_o=64'h00000000_FFFFFFFF at 33 cycles.
REQ-030 Assert rst asynchronously at cnt==20 -> ready_o=0 and result_o=0 without a clock edge.
- After release, signed 0x80000000/0xFFFFFFFF -> result_o=64'h00000000_80000000.

Source files
------------

// File: rtl/div_if.sv
// Request/response bundle between a pipeline stage and the iterative divider.
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// 32-bit restoring divider, one quotient bit per cycle; result {remainder, quotient}
// is presented 33 cycles after start and held until start drops.
module div (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quot;
    logic [31:0] divisor;
    logic        neg_quot;
    logic        neg_rem;
    logic [63:0] result;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [32:0] partial;
    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        op1_abs  = (bus.signed_div_i && bus.opdata1_i[31]) ? 32'd0 - bus.opdata1_i : bus.opdata1_i;
        op2_abs  = (bus.signed_div_i && bus.opdata2_i[31]) ? 32'd0 - bus.opdata2_i : bus.opdata2_i;
        partial  = {rem, quot[31]};
        // rem < divisor keeps partial < 2*divisor, so bit 32 of diff is a clean borrow flag
        diff     = partial - {1'b0, divisor};
        quot_fix = neg_quot ? 32'd0 - quot : quot;
        rem_fix  = neg_rem  ? 32'd0 - rem  : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DIV_FREE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_FREE:
                if (bus.start_i && !bus.annul_i)
                    state_next = (bus.opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
            DIV_BY_ZERO:
                state_next = bus.annul_i ? DIV_FREE : DIV_END;
            DIV_ON:
                if (bus.annul_i)       state_next = DIV_FREE;
                else if (cnt == 6'd32) state_next = DIV_END;
            DIV_END:
                if (!bus.start_i) state_next = DIV_FREE;
            default:
                state_next = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quot     <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                DIV_FREE:
                    if (bus.start_i && !bus.annul_i) begin
                        cnt      <= '0;
                        rem      <= '0;
                        quot     <= op1_abs;
                        divisor  <= op2_abs;
                        neg_quot <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                        neg_rem  <= bus.signed_div_i & bus.opdata1_i[31];
                        result   <= '0;
                    end
                DIV_BY_ZERO:
                    result <= '0;
                DIV_ON:
                    if (bus.annul_i) begin
                        cnt <= '0;
                    end else if (cnt == 6'd32) begin
                        result <= {rem_fix, quot_fix};
                    end else begin
                        rem  <= diff[32] ? partial[31:0] : diff[31:0];
                        quot <= {quot[30:0], ~diff[32]};
                        cnt  <= cnt + 6'd1;
                    end
                DIV_END:
                    if (!bus.start_i) result <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ready_o  = (state == DIV_END);
        bus.result_o = (state == DIV_END) ? result : '0;
    end
endmodule

// File: tb/tb_div.sv
// Directed bench for div: latency, signed/unsigned results, divide-by-zero,
// annul, asynchronous reset and operand isolation.
module tb_div;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_if bus ();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        #2;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0", bus.ready_o);
        end
        checks++;
        if (bus.result_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_result: got %h required 0", bus.result_o);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Full operation: 33-cycle latency, operands scrambled mid-run, hold in DivEnd, release
    task automatic test_divide(input logic sd, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expected, input string tag);
        bus.signed_div_i = sd;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                bus.opdata1_i = ~a;
                bus.opdata2_i = b ^ 32'h5;
                bus.signed_div_i = ~sd;
            end
            if (k < 33) begin
                checks++;
                if (bus.ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_ready at edge %0d: got %b required 0", tag, k, bus.ready_o);
                end
            end
        end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_33: got %b required 1", tag, bus.ready_o);
        end
        checks++;
        if (bus.result_o !== expected) begin
            errors++;
            $display("FAIL %s result: got %h required %h", tag, bus.result_o, expected);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== expected) begin
            errors++;
            $display("FAIL %s hold: got ready=%b result=%h required 1 %h", tag, bus.ready_o, bus.result_o, expected);
        end
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            errors++;
            $display("FAIL %s release: got ready=%b result=%h required 0 0", tag, bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_div_zero();
        bus.signed_div_i = 1'b1;
        bus.opdata1_i = 32'h12345678;
        bus.opdata2_i = 32'h0;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL dz_e0_ready: got %b required 0", bus.ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h0) begin
                errors++;
                $display("FAIL dz_hold cycle %0d: got ready=%b result=%h required 1 0", k, bus.ready_o, bus.result_o);
            end
        end
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL dz_release: got %b required 0", bus.ready_o);
        end
    endtask

    task automatic test_annul();
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'hDEADBEEF;
        bus.opdata2_i = 32'h3;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 10; k++) @(posedge clk);
        #1 bus.annul_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            errors++;
            $display("FAIL annul_free: got ready=%b result=%h required 0 0", bus.ready_o, bus.result_o);
        end
        bus.annul_i = 1'b0;
        test_divide(1'b0, 32'hFFFFFFFF, 32'h1, 64'h00000000_FFFFFFFF, "after_annul");
    endtask

    task automatic test_async_reset();
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'h12345678;
        bus.opdata2_i = 32'h77;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) @(posedge clk);
        #2 rst = 1'b1;
        bus.start_i = 1'b0;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid_op: got ready=%b result=%h required 0 0", bus.ready_o, bus.result_o);
        end
        @(posedge clk); #1 rst = 1'b0;
        test_divide(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "overflow");

        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd10;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 33; k++) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000000_00000064) begin
            errors++;
            $display("FAIL end_before_rst: got ready=%b result=%h required 1 0000000000000064", bus.ready_o, bus.result_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            errors++;
            $display("FAIL rst_in_end: got ready=%b result=%h required 0 0", bus.ready_o, bus.result_o);
        end
        bus.start_i = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_divide(1'b0, 32'hFFFFFFFF, 32'h00010000, 64'h0000FFFF_0000FFFF, "b2b_unsigned");
        test_divide(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, "b2b_neg_neg");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_divide(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "unsigned_100_7");
        test_divide(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "signed_m7_2");
        test_divide(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "signed_7_m2");
        test_div_zero();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
